// File: rtl/wisc_loader_pkg.sv
// Shared types and widths for the WISC-SC15 instruction-memory loader.
package wisc_loader_pkg;

    localparam int LEN_W  = 16;
    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        HDR_HI  = 3'd0,
        HDR_LO  = 3'd1,
        DATA_HI = 3'd2,
        DATA_LO = 3'd3,
        CSUM    = 3'd4,
        DONE    = 3'd5,
        ERR     = 3'd6
    } ld_state_t;

endpackage

// File: rtl/imem_loader.sv
// Boot loader: parses a length-prefixed, XOR-checksummed byte stream into
// 16-bit instruction-memory writes and holds the CPU in reset until the
// whole image has been written and verified.
module imem_loader
    import wisc_loader_pkg::*;
#(
    parameter int unsigned      DEPTH     = 1024,
    parameter logic [LEN_W-1:0] BASE_ADDR = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              in_ready,
    output logic              im_we,
    output logic [LEN_W-1:0]  im_addr,
    output logic [LEN_W-1:0]  im_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              err
);

    ld_state_t         state;
    logic [LEN_W-1:0]  count;     // header assembly, then words remaining
    logic [BYTE_W-1:0] hi_byte;
    logic [BYTE_W-1:0] csum;
    logic [LEN_W-1:0]  wptr;

    logic              fire;
    logic [LEN_W-1:0]  len_word;

    // The loader accepts bytes in every parsing state; terminal states stall the host.
    assign in_ready = (state != DONE) && (state != ERR);
    assign fire     = in_valid && in_ready;
    // LEN_HI was parked in the top byte of count while waiting for LEN_LO.
    assign len_word = {count[LEN_W-1:BYTE_W], in_data};

    // Stream parser FSM with its datapath registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= HDR_HI;
            count    <= '0;
            hi_byte  <= '0;
            csum     <= '0;
            wptr     <= BASE_ADDR;
            im_we    <= 1'b0;
            im_addr  <= BASE_ADDR;
            im_wdata <= '0;
            cpu_rst  <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            im_we <= 1'b0;
            case (state)
                HDR_HI: if (fire) begin
                    count <= {in_data, {BYTE_W{1'b0}}};
                    state <= HDR_LO;
                end
                HDR_LO: if (fire) begin
                    count <= len_word;
                    if (32'(len_word) > DEPTH) begin
                        state <= ERR;
                        err   <= 1'b1;
                    end else if (len_word == '0) begin
                        state <= CSUM;
                    end else begin
                        state <= DATA_HI;
                    end
                end
                DATA_HI: if (fire) begin
                    hi_byte <= in_data;
                    csum    <= csum ^ in_data;
                    state   <= DATA_LO;
                end
                DATA_LO: if (fire) begin
                    im_we    <= 1'b1;
                    im_addr  <= wptr;
                    im_wdata <= {hi_byte, in_data};
                    wptr     <= wptr + 16'd1;
                    csum     <= csum ^ in_data;
                    count    <= count - 16'd1;
                    state    <= (count == 16'd1) ? CSUM : DATA_HI;
                end
                CSUM: if (fire) begin
                    if (in_data == csum) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        cpu_rst <= 1'b0;
                    end else begin
                        state <= ERR;
                        err   <= 1'b1;
                    end
                end
                DONE, ERR: if (start) begin
                    // Re-arm for a fresh image; any byte offered this cycle waits.
                    state   <= HDR_HI;
                    count   <= '0;
                    csum    <= '0;
                    wptr    <= BASE_ADDR;
                    done    <= 1'b0;
                    err     <= 1'b0;
                    cpu_rst <= 1'b1;
                end
                default: state <= HDR_HI;
            endcase
        end
    end

endmodule
